cursor_ctrl: RTL and testbench

CURSOR_CTRL -- requirements
Module: cursor_ctrl

---
 rtl/go_pkg.sv | 53 +++++
 rtl/debounce.sv | 53 +++++
 rtl/cursor_ctrl.sv | 136 +++++++++++++
 tb/tb_cursor_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/go_pkg.sv
// go_pkg: shared types and constants for the Go board front end.
//   BOARD_SIZE     - board edge length (9x9)
//   coord_t        - 4-bit row/column coordinate, 0..BOARD_SIZE-1
//   move_t         - packed {row, col} board position
//   cell_t         - board cell encoding
//   rpt_state_t    - per-direction auto-repeat FSM state
//   coord_step()   - wrapping +/-1 on a coordinate
package go_pkg;

    localparam int BOARD_SIZE = 9;

    typedef logic [3:0] coord_t;

    typedef struct packed {
        coord_t row;
        coord_t col;
    } move_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'b00,
        RPT_DELAY  = 2'b01,
        RPT_REPEAT = 2'b10
    } rpt_state_t;

    localparam move_t CURSOR_HOME = '{row: 4'd4, col: 4'd4};

    // Button bit positions in the packed button vectors.
    localparam int NUM_DIR    = 4;
    localparam int NUM_BTN    = 5;
    localparam int DIR_UP     = 0;
    localparam int DIR_DOWN   = 1;
    localparam int DIR_LEFT   = 2;
    localparam int DIR_RIGHT  = 3;
    localparam int BTN_CENTER = 4;

    // One wrapping step; inc and dec together cancel.
    function automatic coord_t coord_step(input coord_t c, input logic inc, input logic dec);
        coord_t r;
        r = c;
        if (inc && !dec)
            r = (c == coord_t'(BOARD_SIZE - 1)) ? coord_t'(0) : c + coord_t'(1);
        else if (dec && !inc)
            r = (c == coord_t'(0)) ? coord_t'(BOARD_SIZE - 1) : c - coord_t'(1);
        return r;
    endfunction

endpackage

// File: rtl/debounce.sv
// debounce: 2-FF synchronizer, stable-count debouncer and rising-edge detect
// for one raw pushbutton.
//   clk_in  - clock
//   reset   - asynchronous active-high reset
//   btn_raw - raw asynchronous button, active high
//   level   - debounced level
//   press   - one-cycle pulse, registered, one cycle after level rises
module debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_0;
    logic          sync_1;
    logic          level_q;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_0  <= 1'b0;
            sync_1  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_0  <= btn_raw;
            sync_1  <= sync_0;
            level_q <= level;
            press   <= level & ~level_q;
            // Count cycles the synchronized input disagrees with level;
            // any cycle of agreement (a bounce back) restarts the count.
            if (sync_1 != level) begin
                if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync_1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: board cursor driven by five pushbuttons.
//   clk_in      - clock
//   reset       - asynchronous active-high reset
//   btn_up/down/left/right/center - raw pushbuttons, active high
//   locked      - move entry refused (not this player's turn)
//   move_in     - registered cursor position {row, col}, each 0..8
//   make_move   - one-cycle move request at the current position
module cursor_ctrl
    import go_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    input  logic       locked,
    output logic [7:0] move_in,
    output logic       make_move
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_DIR-1:0] step;

    assign btn_raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_in (clk_in),
            .reset  (reset),
            .btn_raw(btn_raw[i]),
            .level  (btn_level[i]),
            .press  (btn_press[i])
        );
    end

    // Per-direction auto-repeat. cnt restarts on every state change and
    // on every repeat step, so it always counts cycles within a phase.
    for (genvar d = 0; d < NUM_DIR; d++) begin : g_rpt
        rpt_state_t    state;
        rpt_state_t    state_nxt;
        logic [RW-1:0] cnt;
        logic          delay_done;
        logic          rate_done;

        assign delay_done = (cnt == RW'(REPEAT_DELAY - 1));
        assign rate_done  = (cnt == RW'(REPEAT_RATE - 1));

        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                state <= RPT_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                if (state_nxt != state || (state == RPT_REPEAT && rate_done))
                    cnt <= '0;
                else if (state != RPT_IDLE)
                    cnt <= cnt + 1'b1;
            end
        end

        always_comb begin
            state_nxt = state;
            case (state)
                RPT_IDLE:   if (btn_press[d]) state_nxt = RPT_DELAY;
                RPT_DELAY:  if (!btn_level[d]) state_nxt = RPT_IDLE;
                            else if (delay_done) state_nxt = RPT_REPEAT;
                RPT_REPEAT: if (!btn_level[d]) state_nxt = RPT_IDLE;
                default:    state_nxt = RPT_IDLE;
            endcase
        end

        always_comb begin
            step[d] = btn_press[d];
            if (btn_level[d]) begin
                if (state == RPT_DELAY && delay_done)
                    step[d] = 1'b1;
                if (state == RPT_REPEAT && rate_done)
                    step[d] = 1'b1;
            end
        end
    end

    // Cursor register. Steps arriving with an accepted center press are
    // parked in pend so make_move reports the pre-step position; pend is
    // applied ahead of any new steps on the following cycle.
    move_t              pos;
    move_t              base;
    move_t              pos_nxt;
    logic [NUM_DIR-1:0] pend;
    logic [NUM_DIR-1:0] pend_nxt;
    logic               center_go;

    always_comb begin
        // press implies a high level; both are required so the center
        // debouncer output is fully qualified here.
        center_go = btn_press[BTN_CENTER] & btn_level[BTN_CENTER] & ~locked;
        base.row  = coord_step(pos.row, pend[DIR_DOWN], pend[DIR_UP]);
        base.col  = coord_step(pos.col, pend[DIR_RIGHT], pend[DIR_LEFT]);
        pos_nxt   = base;
        pend_nxt  = '0;
        if (center_go) begin
            pend_nxt = step;
        end else begin
            pos_nxt.row = coord_step(base.row, step[DIR_DOWN], step[DIR_UP]);
            pos_nxt.col = coord_step(base.col, step[DIR_RIGHT], step[DIR_LEFT]);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pos       <= CURSOR_HOME;
            pend      <= '0;
            make_move <= 1'b0;
        end else begin
            pos       <= pos_nxt;
            pend      <= pend_nxt;
            make_move <= center_go;
        end
    end

    assign move_in = pos;

endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed stimulus with a scoreboard queue of expected
// output events {cycle, move_in, make_move}; a monitor pops and compares
// on every cycle where move_in changes or make_move is high.
module tb_cursor_ctrl;

    typedef struct {
        int         cyc;
        logic [7:0] mv;
        logic       mm;
    } exp_t;

    localparam logic [4:0] B_UP     = 5'b00001;
    localparam logic [4:0] B_DOWN   = 5'b00010;
    localparam logic [4:0] B_LEFT   = 5'b00100;
    localparam logic [4:0] B_RIGHT  = 5'b01000;
    localparam logic [4:0] B_CENTER = 5'b10000;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic       btn_right = 1'b0, btn_center = 1'b0, locked = 1'b0;
    logic [7:0] move_in;
    logic       make_move;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0;
    exp_t q[$];
    logic [7:0] last_mv = 8'h44;

    cursor_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_RATE    (3)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_center(btn_center),
        .locked    (locked),
        .move_in   (move_in),
        .make_move (make_move)
    );

    always #5 clk_in = ~clk_in;

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (move_in !== last_mv || make_move !== 1'b0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: cyc=%0d move_in=%h make_move=%b, required no event",
                             cyc, move_in, make_move);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.mv !== move_in || e.mm !== make_move) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d move_in=%h make_move=%b, required cyc=%0d move_in=%h make_move=%b",
                                 cyc, move_in, make_move, e.cyc, e.mv, e.mm);
                    end
                end
                last_mv = move_in;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic expect_ev(input int c, input logic [7:0] mv, input logic mm);
        exp_t e;
        e.cyc = c;
        e.mv  = mv;
        e.mm  = mm;
        q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] m);
        btn_up     = m[0];
        btn_down   = m[1];
        btn_left   = m[2];
        btn_right  = m[3];
        btn_center = m[4];
    endtask

    task automatic hold_btns(input logic [4:0] m, input int hold, input int gap);
        drive(m);
        tick(hold);
        drive(5'b00000);
        tick(gap);
    endtask

    initial begin
        logic [7:0] up_exp [5];
        up_exp = '{8'h35, 8'h25, 8'h15, 8'h05, 8'h85};

        // Reset state
        tick(3);
        checks++;
        if (move_in !== 8'h44) begin
            errors++;
            $display("FAIL reset_move_in: got %h, required 44", move_in);
        end
        checks++;
        if (make_move !== 1'b0) begin
            errors++;
            $display("FAIL reset_make_move: got %b, required 0", make_move);
        end
        reset = 1'b0;
        tick(2);

        // Clean right press: step lands 2+4+2 cycles after the press
        t0 = cyc; expect_ev(t0 + 8, 8'h45, 1'b0);
        hold_btns(B_RIGHT, 8, 10);

        // Up taps down to row 0, then wrap to 8
        foreach (up_exp[i]) begin
            t0 = cyc; expect_ev(t0 + 8, up_exp[i], 1'b0);
            hold_btns(B_UP, 8, 10);
        end

        // Down held: press step, first repeat 8 later, then every 3; wraps 8->0
        t0 = cyc;
        expect_ev(t0 + 8,  8'h05, 1'b0);
        expect_ev(t0 + 16, 8'h15, 1'b0);
        expect_ev(t0 + 19, 8'h25, 1'b0);
        expect_ev(t0 + 22, 8'h35, 1'b0);
        expect_ev(t0 + 25, 8'h45, 1'b0);
        expect_ev(t0 + 28, 8'h55, 1'b0);
        expect_ev(t0 + 31, 8'h65, 1'b0);
        hold_btns(B_DOWN, 26, 10);
        tick(20);

        t0 = cyc; expect_ev(t0 + 8, 8'h55, 1'b0); hold_btns(B_UP, 8, 10);
        t0 = cyc; expect_ev(t0 + 8, 8'h45, 1'b0); hold_btns(B_UP, 8, 10);
        t0 = cyc; expect_ev(t0 + 8, 8'h44, 1'b0); hold_btns(B_LEFT, 8, 10);

        // Center held unlocked: exactly one make_move
        t0 = cyc; expect_ev(t0 + 8, 8'h44, 1'b1);
        hold_btns(B_CENTER, 30, 10);

        // Center while locked: discarded, even after locked falls
        locked = 1'b1;
        hold_btns(B_CENTER, 8, 10);
        locked = 1'b0;
        tick(10);

        // Opposing steps cancel; row + column steps both apply
        hold_btns(B_LEFT | B_RIGHT, 8, 10);
        t0 = cyc; expect_ev(t0 + 8, 8'h35, 1'b0); hold_btns(B_UP | B_RIGHT, 8, 10);
        t0 = cyc; expect_ev(t0 + 8, 8'h44, 1'b0); hold_btns(B_DOWN | B_LEFT, 8, 10);

        // Step with accepted center: make_move at old position, step deferred
        t0 = cyc;
        expect_ev(t0 + 8, 8'h44, 1'b1);
        expect_ev(t0 + 9, 8'h45, 1'b0);
        hold_btns(B_RIGHT | B_CENTER, 8, 10);

        // Step with refused center: step applies normally
        locked = 1'b1;
        t0 = cyc; expect_ev(t0 + 8, 8'h44, 1'b0);
        hold_btns(B_LEFT | B_CENTER, 8, 10);
        locked = 1'b0;

        // Bouncing right then stable: one press step, repeats, then reset mid-repeat
        t0 = cyc;
        expect_ev(t0 + 16, 8'h45, 1'b0);
        expect_ev(t0 + 24, 8'h46, 1'b0);
        expect_ev(t0 + 27, 8'h47, 1'b0);
        expect_ev(t0 + 28, 8'h44, 1'b0);
        btn_right = 1'b1; tick(2);
        btn_right = 1'b0; tick(2);
        btn_right = 1'b1; tick(2);
        btn_right = 1'b0; tick(2);
        btn_right = 1'b1; tick(20);
        reset = 1'b1;
        btn_right = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(40);

        // Every expected event must have been consumed
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d expected events never seen, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
